// File: rtl/mips32_if_stage.sv
// MIPS32 instruction-fetch stage: word-addressed PC, single-outstanding
// instruction memory request, one-entry skid buffer for responses that
// land during a stall, branch redirect with stale-response discard, and
// halt on the HLT opcode.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | fetch disabled, no request outstanding
//   S_REQ  | request for PC presented this cycle (unless stalled/redirected)
//   S_WAIT | one request outstanding, or response parked in skid buffer
//   S_HALT | HLT delivered; fetch frozen until a redirect or reset
module mips32_if_stage #(
  parameter logic [5:0]  HLT_OP   = 6'b111111,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_ir_o,
  output logic [31:0] if_id_npc_o,
  output logic        if_id_valid_o,
  output logic [31:0] pc_o,
  output logic        halted_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        skid_valid;
  logic [31:0] skid_data;
  logic        discard;

  logic        have_data;
  logic [31:0] fetch_word;
  logic        write_en;
  logic        is_hlt;
  logic [31:0] pc_inc;
  state_t      after_fetch;

  // Response availability, IF/ID write qualification and next-PC arithmetic
  always_comb begin
    have_data   = skid_valid | (imem_valid_i & ~discard);
    fetch_word  = skid_valid ? skid_data : imem_rdata_i;
    write_en    = (state == S_WAIT) & have_data & ~stall_i & ~br_taken_i;
    is_hlt      = (fetch_word[31:26] == HLT_OP);
    pc_inc      = pc + 32'd1;
    after_fetch = en ? S_REQ : S_IDLE;
  end

  // The request strobe is qualified by stall and redirect in the same
  // cycle: a stalled REQ must not issue, and a REQ coinciding with a
  // redirect would fetch the stale PC. The address is the PC register.
  always_comb begin
    imem_req_o  = (state == S_REQ) & ~stall_i & ~br_taken_i;
    imem_addr_o = pc;
    pc_o        = pc;
  end

  // Fetch FSM, PC, IF/ID register, skid buffer and discard flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      skid_valid    <= 1'b0;
      skid_data     <= 32'd0;
      discard       <= 1'b0;
      if_id_ir_o    <= 32'd0;
      if_id_npc_o   <= 32'd0;
      if_id_valid_o <= 1'b0;
      halted_o      <= 1'b0;
    end else if (br_taken_i) begin
      pc            <= br_target_i;
      if_id_valid_o <= 1'b0;
      if_id_ir_o    <= 32'd0;
      skid_valid    <= 1'b0;
      halted_o      <= 1'b0;
      case (state)
        S_IDLE: begin
          state   <= S_IDLE;
          discard <= 1'b0;
        end
        S_REQ: begin
          state   <= S_REQ;
          discard <= 1'b0;
        end
        S_WAIT: begin
          // A response is still in flight only if nothing has arrived yet;
          // that one must be swallowed when it shows up.
          if (!skid_valid && !imem_valid_i) begin
            state   <= S_WAIT;
            discard <= 1'b1;
          end else begin
            state   <= after_fetch;
            discard <= 1'b0;
          end
        end
        S_HALT: begin
          state   <= S_REQ;
          discard <= 1'b0;
        end
      endcase
    end else begin
      // A live IF/ID entry is consumed whenever downstream is not stalled.
      if (!stall_i) begin
        if_id_valid_o <= write_en;
      end
      case (state)
        S_IDLE: begin
          if (en && !stall_i) begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!stall_i) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_valid_i && discard) begin
            discard <= 1'b0;
            state   <= after_fetch;
          end else if (have_data) begin
            if (stall_i) begin
              if (!skid_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= imem_rdata_i;
              end
            end else begin
              if_id_ir_o  <= fetch_word;
              if_id_npc_o <= pc_inc;
              pc          <= pc_inc;
              skid_valid  <= 1'b0;
              if (is_hlt) begin
                state    <= S_HALT;
                halted_o <= 1'b1;
              end else begin
                state <= after_fetch;
              end
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_if_stage.sv
// Directed bench for mips32_if_stage with a small instruction-memory
// responder of programmable latency.
module tb_mips32_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_id_ir_o;
  logic [31:0] if_id_npc_o;
  logic        if_id_valid_o;
  logic [31:0] pc_o;
  logic        halted_o;

  int n_assert = 0;
  int n_fail   = 0;

  int          resp_lat = 1;
  int          req_cnt  = 0;
  bit          pend     = 1'b0;
  int          cnt      = 0;
  logic [31:0] paddr    = 32'd0;
  logic        sreq;
  logic [31:0] saddr;
  int          rc;

  mips32_if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .stall_i       (stall_i),
    .br_taken_i    (br_taken_i),
    .br_target_i   (br_target_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_valid_i  (imem_valid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_ir_o    (if_id_ir_o),
    .if_id_npc_o   (if_id_npc_o),
    .if_id_valid_o (if_id_valid_o),
    .pc_o          (pc_o),
    .halted_o      (halted_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'd0) return 32'h03E0A800;
    if (a == 32'd3) return 32'hFC000000;
    return 32'h1000_0000 + a;
  endfunction

  // Memory responder: samples the request at negedge, answers resp_lat
  // cycles later for one cycle.
  always begin
    @(negedge clk);
    sreq  = imem_req_o;
    saddr = imem_addr_o;
    @(posedge clk);
    #1;
    imem_valid_i = 1'b0;
    if (sreq) begin
      req_cnt++;
      pend  = 1'b1;
      cnt   = resp_lat;
      paddr = saddr;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend         = 1'b0;
        imem_valid_i = 1'b1;
        imem_rdata_i = mem(paddr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},    pc_o, 32'd0);
    chk({tag, "_req"},   {31'd0, imem_req_o}, 32'd0);
    chk({tag, "_addr"},  imem_addr_o, 32'd0);
    chk({tag, "_ir"},    if_id_ir_o, 32'd0);
    chk({tag, "_npc"},   if_id_npc_o, 32'd0);
    chk({tag, "_valid"}, {31'd0, if_id_valid_o}, 32'd0);
    chk({tag, "_halt"},  {31'd0, halted_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    en           = 1'b0;
    stall_i      = 1'b0;
    br_taken_i   = 1'b0;
    br_target_i  = 32'd0;
    imem_valid_i = 1'b0;
    imem_rdata_i = 32'd0;
    tick();
    tick();
    chk_reset("rst");

    // First fetch from reset, then throughput of one per two cycles
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    chk("f0_req",  {31'd0, imem_req_o}, 32'd1);
    chk("f0_addr", imem_addr_o, 32'd0);
    tick();
    chk("f0_wait_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    chk("f0_ir",    if_id_ir_o, 32'h03E0A800);
    chk("f0_npc",   if_id_npc_o, 32'd1);
    chk("f0_valid", {31'd0, if_id_valid_o}, 32'd1);
    chk("f0_pc",    pc_o, 32'd1);
    chk("f1_req",   {31'd0, imem_req_o}, 32'd1);
    chk("f1_addr",  imem_addr_o, 32'd1);
    tick();
    chk("f1_consumed", {31'd0, if_id_valid_o}, 32'd0);
    tick();
    chk("f1_ir",    if_id_ir_o, 32'h10000001);
    chk("f1_valid", {31'd0, if_id_valid_o}, 32'd1);
    chk("f2_addr",  imem_addr_o, 32'd2);

    // Stall over the addr-2 response
    tick();
    chk("s_valid0", {31'd0, if_id_valid_o}, 32'd0);
    rc      = req_cnt;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s_pc",    pc_o, 32'd2);
      chk("s_ir",    if_id_ir_o, 32'h10000001);
      chk("s_valid", {31'd0, if_id_valid_o}, 32'd0);
      chk("s_req",   {31'd0, imem_req_o}, 32'd0);
    end
    stall_i = 1'b0;
    tick();
    chk("s_ir_out", if_id_ir_o, 32'h10000002);
    chk("s_npc",    if_id_npc_o, 32'd3);
    chk("s_pc_out", pc_o, 32'd3);
    chk("s_vout",   {31'd0, if_id_valid_o}, 32'd1);
    chk("s_nodup",  req_cnt, rc);
    chk("s_next",   imem_addr_o, 32'd3);

    // HLT at addr 3
    tick();
    tick();
    chk("h_ir",    if_id_ir_o, 32'hFC000000);
    chk("h_halt",  {31'd0, halted_o}, 32'd1);
    chk("h_pc",    pc_o, 32'd4);
    chk("h_valid", {31'd0, if_id_valid_o}, 32'd1);
    rc = req_cnt;
    repeat (20) tick();
    chk("h_noreq",  req_cnt, rc);
    chk("h_still",  {31'd0, halted_o}, 32'd1);
    chk("h_pc20",   pc_o, 32'd4);
    br_taken_i  = 1'b1;
    br_target_i = 32'd0;
    tick();
    br_taken_i = 1'b0;
    #1;
    chk("h_res_pc",   pc_o, 32'd0);
    chk("h_res_halt", {31'd0, halted_o}, 32'd0);
    chk("h_res_req",  {31'd0, imem_req_o}, 32'd1);
    chk("h_res_addr", imem_addr_o, 32'd0);
    tick();
    tick();
    chk("h_res_ir", if_id_ir_o, 32'h03E0A800);
    chk("h_res_npc", if_id_npc_o, 32'd1);

    // Redirect while waiting on addr 5
    br_taken_i  = 1'b1;
    br_target_i = 32'd5;
    tick();
    br_taken_i = 1'b0;
    #1;
    chk("b_addr5", imem_addr_o, 32'd5);
    chk("b_req5",  {31'd0, imem_req_o}, 32'd1);
    resp_lat = 3;
    tick();
    br_taken_i  = 1'b1;
    br_target_i = 32'h40;
    tick();
    br_taken_i = 1'b0;
    resp_lat   = 1;
    #1;
    chk("b_pc",    pc_o, 32'h40);
    chk("b_valid", {31'd0, if_id_valid_o}, 32'd0);
    chk("b_req0",  {31'd0, imem_req_o}, 32'd0);
    tick();
    chk("b_req1",  {31'd0, imem_req_o}, 32'd0);
    tick();
    chk("b_drop_valid", {31'd0, if_id_valid_o}, 32'd0);
    chk("b_drop_ir",    if_id_ir_o, 32'd0);
    chk("b_req40",      {31'd0, imem_req_o}, 32'd1);
    chk("b_addr40",     imem_addr_o, 32'h40);
    tick();
    tick();
    chk("b_ir40",  if_id_ir_o, 32'h10000040);
    chk("b_npc40", if_id_npc_o, 32'h41);

    // PC wrap at 32'hFFFFFFFF
    br_taken_i  = 1'b1;
    br_target_i = 32'hFFFFFFFF;
    #1;
    chk("w_brgate", {31'd0, imem_req_o}, 32'd0);
    tick();
    br_taken_i = 1'b0;
    #1;
    chk("w_addr", imem_addr_o, 32'hFFFFFFFF);
    tick();
    tick();
    chk("w_npc",  if_id_npc_o, 32'd0);
    chk("w_pc",   pc_o, 32'd0);
    chk("w_ir",   if_id_ir_o, 32'h0FFFFFFF);
    chk("w_next", imem_addr_o, 32'd0);

    // Redirect coincident with the response
    tick();
    br_taken_i  = 1'b1;
    br_target_i = 32'h20;
    tick();
    br_taken_i = 1'b0;
    #1;
    chk("c_req",   {31'd0, imem_req_o}, 32'd1);
    chk("c_addr",  imem_addr_o, 32'h20);
    chk("c_ir",    if_id_ir_o, 32'd0);
    chk("c_valid", {31'd0, if_id_valid_o}, 32'd0);
    tick();
    tick();
    chk("c_ir20",  if_id_ir_o, 32'h10000020);
    chk("c_v20",   {31'd0, if_id_valid_o}, 32'd1);

    // en dropped during WAIT
    tick();
    en = 1'b0;
    tick();
    chk("e_ir",    if_id_ir_o, 32'h10000021);
    chk("e_pc",    pc_o, 32'h22);
    chk("e_valid", {31'd0, if_id_valid_o}, 32'd1);
    chk("e_req",   {31'd0, imem_req_o}, 32'd0);
    tick();
    chk("e_idle",  {31'd0, imem_req_o}, 32'd0);

    // Reset pulse mid-WAIT with a late response
    en = 1'b1;
    tick();
    chk("r_req",  {31'd0, imem_req_o}, 32'd1);
    chk("r_addr", imem_addr_o, 32'h22);
    resp_lat = 3;
    tick();
    en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("r_async");
    tick();
    rst_n    = 1'b1;
    resp_lat = 1;
    repeat (4) tick();
    chk_reset("r_late");
    en = 1'b1;
    tick();
    chk("r_first_req",  {31'd0, imem_req_o}, 32'd1);
    chk("r_first_addr", imem_addr_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips32_if_stage.md
MIPS32_IF_STAGE -- requirements
Module: mips32_if_stage

Interface
REQ-001 Parameter HLT_OP, default 6'b111111, is the halt opcode matched in instruction bits [31:26].
REQ-002 Parameter RESET_PC, default 32'd0, is the PC value loaded at reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  fetch enable; low = no new requests issued.
REQ-006 stall_i  input  1  downstream hazard stall; holds PC and IF/ID.
REQ-007 br_taken_i  input  1  branch/jump redirect from downstream, 1-cycle pulse.
REQ-008 br_target_i  input  32  redirect word address, valid with br_taken_i.
REQ-009 imem_req_o  output  1  instruction memory read request.
REQ-010 imem_addr_o  output  32  word address of request, equals PC while imem_req_o=1.
REQ-011 imem_valid_i  input  1  read data valid, 1 cycle, at least 1 cycle after request.
REQ-012 imem_rdata_i  input  32  instruction word.
REQ-013 if_id_ir_o  output  32  IF/ID instruction register.
REQ-014 if_id_npc_o  output  32  IF/ID next-PC (fetch address + 1).
REQ-015 if_id_valid_o  output  1  IF/ID holds a live instruction.
REQ-016 pc_o  output  32  current PC.
REQ-017 halted_o  output  1  fetch halted by HLT.

Function
REQ-018 PC is word-addressed; sequential increment is +1, 32-bit wrap (32'hFFFFFFFF -> 0).
REQ-019 FSM states IDLE, REQ, WAIT, HALT; IDLE->REQ when en=1 and stall_i=0.
REQ-020 REQ: imem_req_o=1 for exactly one cycle with imem_addr_o=PC; next state WAIT.
REQ-021 At most one request outstanding; no imem_req_o while in WAIT or HALT.
REQ-022 WAIT, imem_valid_i=1, stall_i=0, no redirect: if_id_ir_o<=rdata, if_id_npc_o<=PC+1, if_id_valid_o<=1, PC<=PC+1; next REQ if en=1, else IDLE.
REQ-023 WAIT, imem_valid_i=1, stall_i=1: data captured into one-entry skid buffer; IF/ID and PC hold; buffer drains to IF/ID on first cycle stall_i=0, same updates as REQ-022.
REQ-024 Stall with no live response: IF/ID, PC, FSM state hold; no request issued.
REQ-025 if_id_valid_o cleared on the edge a live IF/ID entry is consumed (stall_i=0) and no new instruction is written.
REQ-026 br_taken_i=1 has priority over stall_i, imem_valid_i and halt: PC<=br_target_i, if_id_valid_o<=0, if_id_ir_o<=32'd0, skid buffer cleared, halted_o<=0.
REQ-027 Redirect while in WAIT: set discard flag; the pending response is dropped on arrival, then REQ at new PC.
REQ-028 Redirect coincident with imem_valid_i: response dropped, no discard flag left set.
REQ-029 Written instruction with bits[31:26]==HLT_OP: delivered to IF/ID normally, FSM->HALT, halted_o<=1, PC<=PC+1.
REQ-030 HALT exits only on br_taken_i (to REQ at target) or reset.
REQ-031 en deasserted in WAIT: response still completes per REQ-022, then IDLE.
REQ-032 Full fetch throughput: one instruction per 2 cycles with zero-wait memory.

Reset
REQ-033 rst_n=0 asynchronously: PC=RESET_PC, FSM=IDLE, imem_req_o=0, imem_addr_o=RESET_PC, if_id_ir_o=0, if_id_npc_o=0, if_id_valid_o=0, halted_o=0, skid and discard flags cleared.
REQ-034 Reset mid-WAIT: the later imem_valid_i is ignored; first request after release at RESET_PC.

Verification
REQ-035 Reset release, en=1, memory returns 0x03E0A800 one cycle after request -> req addr 0, IF/ID IR=0x03E0A800, NPC=1, valid=1, next req addr 1.
REQ-036 stall_i high 3 cycles over response to addr 2 -> IF/ID, PC unchanged 3 cycles; IR delivered first cycle after stall drops, no duplicate request.
REQ-037 br_taken_i with target 0x40 while WAIT on addr 5 -> addr-5 data dropped, valid=0, next request addr 0x40.
REQ-038 Fetch word 0xFC000000 at addr 3 -> IF/ID IR=0xFC000000, halted_o=1, PC=4, no further requests for 20 cycles; br_taken_i target 0 resumes at 0.
REQ-039 rst_n pulsed low mid-WAIT -> outputs at reset values immediately; late imem_valid_i ignored.
REQ-040 PC=32'hFFFFFFFF fetch -> NPC=0, next request addr 0.
